// File: rtl/bin_dec_seq.sv
// Sequential binary-to-BCD converter (shift-add-3). Each conversion takes
// BIN_W SHIFT cycles plus one FIN cycle, so results come back to back every BIN_W+1 cycles.
module bin_dec_seq #(
    parameter int BIN_W  = 15,
    parameter int DIGITS = 5
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  START,
    input  logic [BIN_W-1:0]      BIN_IN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   DEC_OUT,
    output logic                  OVF
);
    localparam int CW = $clog2(BIN_W + 1);
    localparam int AW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d, adj;
    logic [BIN_W-1:0] sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            flag_q, flag_d;
    logic [AW-1:0]   dec_q, dec_d;
    logic            ovf_q, ovf_d;

    // Add 3 to every digit >= 5 before the shift so it carries correctly into the next digit.
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        dec_d   = dec_q;
        ovf_d   = ovf_q;
        case (state_q)
            SHIFT: begin
                acc_d  = {adj[AW-2:0], sr_q[BIN_W-1]};
                sr_d   = sr_q << 1;
                flag_d = flag_q | adj[AW-1];
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIN;
                    dec_d   = flag_d ? {DIGITS{4'h9}} : acc_d;
                    ovf_d   = flag_d;
                end
            end
            default: begin
                if (state_q == FIN)
                    state_d = IDLE;
                if (START) begin
                    state_d = SHIFT;
                    sr_d    = BIN_IN;
                    acc_d   = '0;
                    flag_d  = 1'b0;
                    cnt_d   = CW'(BIN_W);
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            acc_q   <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            dec_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            dec_q   <= dec_d;
            ovf_q   <= ovf_d;
        end
    end

    assign BUSY    = (state_q == SHIFT);
    assign DONE    = (state_q == FIN);
    assign DEC_OUT = dec_q;
    assign OVF     = ovf_q;
endmodule

// File: tb/tb_bin_dec_seq.sv
// Bench for bin_dec_seq: a default-size converter and a 7-bit/2-digit one sharing clock and reset.
module tb_bin_dec_seq;
    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        d_start = 1'b0, s_start = 1'b0;
    logic [14:0] d_bin = '0;
    logic [6:0]  s_bin = '0;
    logic        d_busy, d_done, d_ovf, s_busy, s_done, s_ovf;
    logic [19:0] d_dec;
    logic [7:0]  s_dec;
    int          tests = 0, fails = 0;

    always #5 CLK = ~CLK;

    bin_dec_seq u_d (
        .CLK(CLK), .RESET_N(RESET_N), .START(d_start), .BIN_IN(d_bin),
        .BUSY(d_busy), .DONE(d_done), .DEC_OUT(d_dec), .OVF(d_ovf)
    );

    bin_dec_seq #(.BIN_W(7), .DIGITS(2)) u_s (
        .CLK(CLK), .RESET_N(RESET_N), .START(s_start), .BIN_IN(s_bin),
        .BUSY(s_busy), .DONE(s_done), .DEC_OUT(s_dec), .OVF(s_ovf)
    );

    typedef struct {
        bit          sel;
        int          bin;
        logic [19:0] dec;
        logic        ovf;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: repeated divide by 10; saturate to all nines when the value does not fit.
    function automatic logic [20:0] model(input int v, input int nd);
        logic [19:0] d;
        int lim;
        d = '0;
        lim = 1;
        for (int i = 0; i < nd; i++) lim *= 10;
        if (v >= lim) begin
            for (int i = 0; i < nd; i++) d[4*i +: 4] = 4'h9;
            return {1'b1, d};
        end
        for (int i = 0; i < nd; i++) begin
            d[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {1'b0, d};
    endfunction

    // {busy, done, ovf, dec} of the selected instance
    function automatic logic [22:0] rd(input bit sel);
        if (sel) return {s_busy, s_done, s_ovf, 12'h0, s_dec};
        return {d_busy, d_done, d_ovf, d_dec};
    endfunction

    task automatic conv(input bit sel, input int bin, input logic [19:0] exp_dec,
                        input logic exp_ovf, input string nm);
        int          lat;
        bit          ok;
        logic [19:0] prev;
        logic [22:0] o;
        lat = sel ? 7 : 15;
        ok = 1'b1;
        prev = rd(sel) & 23'h0FFFFF;
        @(negedge CLK);
        if (sel) begin s_start = 1'b1; s_bin = bin[6:0]; end
        else     begin d_start = 1'b1; d_bin = bin[14:0]; end
        @(posedge CLK); #1;
        s_start = 1'b0; d_start = 1'b0;
        s_bin = ~bin[6:0]; d_bin = ~bin[14:0];
        for (int k = 0; k < lat; k++) begin
            o = rd(sel);
            if (!(o[22] === 1'b1 && o[21] === 1'b0 && o[19:0] === prev)) ok = 1'b0;
            @(posedge CLK); #1;
        end
        o = rd(sel);
        check({nm, "_lat"}, {31'b0, ok}, 32'd1);
        check({nm, "_done"}, {30'b0, o[22:21]}, 32'b01);
        check({nm, "_dec"}, {12'b0, o[19:0]}, {12'b0, exp_dec});
        check({nm, "_ovf"}, {31'b0, o[20]}, {31'b0, exp_ovf});
        @(posedge CLK); #1;
        o = rd(sel);
        check({nm, "_idle"}, {30'b0, o[22:21]}, 32'b00);
    endtask

    vec_t        vecs[14];
    logic [14:0] hist[80];
    logic [20:0] m;
    bit          both, donebad, seen;

    initial begin
        vecs = '{
            '{0, 12345, 20'h12345, 0}, '{0, 32767, 20'h32767, 0},
            '{0, 0,     20'h00000, 0}, '{0, 1,     20'h00001, 0},
            '{0, 9,     20'h00009, 0}, '{0, 10,    20'h00010, 0},
            '{0, 9999,  20'h09999, 0}, '{0, 10000, 20'h10000, 0},
            '{1, 99,    20'h00099, 0}, '{1, 100,   20'h00099, 1},
            '{1, 127,   20'h00099, 1}, '{1, 0,     20'h00000, 0},
            '{1, 9,     20'h00009, 0}, '{1, 50,    20'h00050, 0}
        };

        #2;
        check("rst_d", {9'b0, rd(0)}, 32'h0);
        check("rst_s", {9'b0, rd(1)}, 32'h0);
        @(negedge CLK); RESET_N = 1'b1;

        foreach (vecs[i])
            conv(vecs[i].sel, vecs[i].bin, vecs[i].dec, vecs[i].ovf, $sformatf("vec%0d", i));

        // START held high, BIN_IN changing every cycle: one result every 16 cycles
        both = 1'b0; donebad = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge CLK);
            d_start = 1'b1;
            d_bin = 15'($urandom_range(0, 32767));
            hist[cyc] = d_bin;
            @(posedge CLK); #1;
            if (d_busy && d_done) both = 1'b1;
            if (d_done !== ((cyc % 16) == 15)) donebad = 1'b1;
            if ((cyc % 16) == 15) begin
                m = model(int'(hist[cyc-15]), 5);
                check($sformatf("b2b%0d_dec", cyc / 16), {12'b0, d_dec}, {12'b0, m[19:0]});
                check($sformatf("b2b%0d_ovf", cyc / 16), {31'b0, d_ovf}, {31'b0, m[20]});
            end
        end
        @(negedge CLK); d_start = 1'b0;
        check("b2b_busy_done_overlap", {31'b0, both}, 32'd0);
        check("b2b_done_timing", {31'b0, donebad}, 32'd0);
        repeat (2) @(posedge CLK);

        // Reset in the middle of SHIFT aborts the conversion
        @(negedge CLK); d_start = 1'b1; d_bin = 15'd12345;
        @(posedge CLK); #1; d_start = 1'b0;
        repeat (7) @(posedge CLK);
        #3; RESET_N = 1'b0; #1;
        check("midrst_out", {9'b0, rd(0)}, 32'h0);
        d_start = 1'b1; d_bin = 15'd4095;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_start_ignored", {9'b0, rd(0)}, 32'h0);
        @(negedge CLK); d_start = 1'b0; RESET_N = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge CLK); #1;
            if (d_done || d_busy) seen = 1'b1;
        end
        check("midrst_no_done", {31'b0, seen}, 32'd0);
        conv(0, 4095, 20'h04095, 1'b0, "after_rst");

        for (int i = 0; i < 100; i++) begin
            int v;
            v = int'($urandom_range(0, 32767));
            m = model(v, 5);
            conv(0, v, m[19:0], m[20], $sformatf("rnd%0d_v%0d", i, v));
        end
        for (int i = 0; i < 20; i++) begin
            int v;
            v = int'($urandom_range(0, 127));
            m = model(v, 2);
            conv(1, v, m[19:0], m[20], $sformatf("srnd%0d_v%0d", i, v));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bin_dec_seq.md
BIN_DEC_SEQ -- requirements
Module: bin_dec_seq

Interface
REQ-001 The block SHALL have parameter BIN_W, default 15: width of the unsigned binary input.
REQ-002 The block SHALL have parameter DIGITS, default 5: number of BCD output digits.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port START, input, 1 bit: conversion request, sampled on the rising edge of CLK.
REQ-006 The block SHALL have port BIN_IN, input, BIN_W bits: unsigned value, sampled only on an accepted START.
REQ-007 The block SHALL have port BUSY, output, 1 bit: high while a conversion is in progress.
REQ-008 The block SHALL have port DONE, output, 1 bit: one-cycle pulse when a result becomes valid.
REQ-009 The block SHALL have port DEC_OUT, output, 4*DIGITS bits: BCD result, digit 0 (units) in bits [3:0].
REQ-010 The block SHALL have port OVF, output, 1 bit: high when the last result did not fit in DIGITS digits.

Function
REQ-011 The block SHALL use an FSM with exactly three states, IDLE, SHIFT and FIN; the reset state SHALL be IDLE.
REQ-012 In IDLE or FIN, START=1 SHALL be accepted: latch BIN_IN into a shift register, clear the BCD accumulator and the overflow flag, set the bit counter to BIN_W, and go to SHIFT.
REQ-013 START SHALL be ignored in SHIFT; BIN_IN changes during SHIFT SHALL NOT affect the result.
REQ-014 Each SHIFT cycle SHALL perform one shift-add-3 step, then decrement the counter: add 3 to every digit >= 5, then shift the {accumulator, shift register} pair left by one bit.
REQ-015 During a SHIFT step, a 1 shifted out of the top digit SHALL set the internal overflow flag, which stays set for the rest of the conversion.
REQ-016 After exactly BIN_W SHIFT cycles the FSM SHALL enter FIN and, on that same edge, load DEC_OUT and OVF.
REQ-017 If the overflow flag is set, DEC_OUT SHALL be loaded with all digits = 9 and OVF with 1; otherwise DEC_OUT SHALL be loaded with the accumulator and OVF with 0.
REQ-018 Latency: with START accepted at edge N, BUSY SHALL be 1 from edge N to edge N+BIN_W, and DONE SHALL be 1 for the single cycle following edge N+BIN_W.
REQ-019 FIN SHALL last one cycle; the FSM then goes to IDLE, or to SHIFT if START=1 in FIN. This gives back-to-back conversions every BIN_W+1 cycles.
REQ-020 DEC_OUT and OVF SHALL hold their values until the next FIN load; they SHALL NOT show intermediate accumulator values.
REQ-021 BUSY SHALL be 1 in SHIFT only, and DONE SHALL be 1 in FIN only; both SHALL be driven directly from registered state.
REQ-022 BIN_IN = 0 SHALL produce DEC_OUT = 0 and OVF = 0 after the full latency; there is no early termination.
REQ-023 BIN_W >= 1 and DIGITS >= 1 SHALL be supported; the counter width SHALL be large enough to hold BIN_W.

Reset
REQ-024 RESET_N = 0 SHALL immediately, regardless of CLK, force: state = IDLE, BUSY = 0, DONE = 0, OVF = 0, DEC_OUT = 0, accumulator, shift register and counter = 0.
REQ-025 A reset during SHIFT or FIN SHALL abort the conversion with no DONE pulse; after release, the block SHALL wait for a new START.
REQ-026 START SHALL be ignored while RESET_N = 0; the first edge that can accept START is the first rising edge with RESET_N = 1.

Verification
REQ-027 Default parameters, BIN_IN = 12345, 1-cycle START -> BUSY high for 15 cycles, DONE pulse on the 16th cycle, DEC_OUT = 0x12345, OVF = 0.
REQ-028 Default parameters, BIN_IN = 32767 -> DEC_OUT = 0x32767, OVF = 0; BIN_IN = 0 -> DEC_OUT = 0x00000 after 16 cycles.
REQ-029 BIN_W = 7, DIGITS = 2: BIN_IN = 99 -> DEC_OUT = 0x99, OVF = 0; BIN_IN = 100 -> DEC_OUT = 0x99, OVF = 1; BIN_IN = 127 -> DEC_OUT = 0x99, OVF = 1.
REQ-030 START held high continuously with BIN_IN changed every cycle -> conversions every 16 cycles, each result matching the BIN_IN value on its accepting edge; DONE and BUSY never high together.
REQ-031 RESET_N pulsed low mid-SHIFT (cycle 7 of 15) -> outputs 0 at once, no DONE; a following START with 4095 -> DEC_OUT = 0x04095.
REQ-032 Randomised check over all 2^15 inputs against a reference divide-by-10 model -> exact match of DEC_OUT and OVF = 0.
